// File: rtl/hh_pkg.sv
// Shared types and widths for the Hodgkin-Huxley spike detector slice.
// The sample format matches the hh_neuron membrane voltage output.
package hh_pkg;

    localparam int W    = 22;
    localparam int TS_W = 16;

    typedef enum logic [1:0] {
        BELOW,
        ABOVE,
        REFRAC
    } spk_state_t;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [W-1:0]    peak;
    } spk_evt_t;

endpackage

// File: rtl/hh_evt_fifo.sv
// Small synchronous FIFO of spike event records.
// Head entry is read combinationally, so it stays put until it is popped.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is reported on 'drop' and discarded.
module hh_evt_fifo
    import hh_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  spk_evt_t push_data,
    input  logic     pop,
    output spk_evt_t head,
    output logic     full,
    output logic     empty,
    output logic     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    spk_evt_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/hh_spike_detector.sv
// Threshold/hysteresis spike detector with refractory window and event FIFO.
// Optional build macro HH_SPIKE_PEAK_EN enables peak tracking; without it
// the peak register is absent and evt_peak is tied to 0.
module hh_spike_detector
    import hh_pkg::*;
#(
    parameter int REFRAC_W   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [W-1:0]        v_mem,
    input  logic                v_valid,
    input  logic [W-1:0]        v_thresh,
    input  logic [W-1:0]        v_hyst,
    input  logic [REFRAC_W-1:0] refrac_cycles,
    output logic                spike,
    output logic [15:0]         spike_count,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [TS_W-1:0]     evt_time,
    output logic [W-1:0]        evt_peak,
    output logic                overflow
);

    // Two extra bits keep v_thresh - v_hyst exact even for extreme settings.
    localparam int CW = W + 2;

    spk_state_t           state;
    spk_state_t           state_next;
    logic signed [CW-1:0] v_ext;
    logic signed [CW-1:0] thr_ext;
    logic signed [CW-1:0] rearm_ext;
    logic                 is_above;
    logic                 below_rearm;
    logic                 start_spike;
    logic                 end_spike;
    logic                 rc_tick;
    logic [REFRAC_W-1:0]  rc;
    logic [TS_W-1:0]      ts;
    logic [TS_W-1:0]      t0;
    spk_evt_t             evt_in;
    spk_evt_t             evt_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;

    assign v_ext       = CW'($signed(v_mem));
    assign thr_ext     = CW'($signed(v_thresh));
    assign rearm_ext   = thr_ext - $signed({2'b00, v_hyst});
    assign is_above    = (v_ext >= thr_ext);
    assign below_rearm = (v_ext < rearm_ext);

    // State register for the detector FSM.
    always_ff @(posedge clk) begin
        if (reset) state <= BELOW;
        else       state <= state_next;
    end

    // Next-state logic; only valid samples move the FSM.
    always_comb begin
        state_next = state;
        case (state)
            BELOW:  if (v_valid && is_above) state_next = ABOVE;
            ABOVE:  if (v_valid && below_rearm)
                        state_next = (refrac_cycles == '0) ? BELOW : REFRAC;
            REFRAC: if (v_valid && rc == REFRAC_W'(1)) state_next = BELOW;
            default: state_next = BELOW;
        endcase
    end

    // Per-state control strobes driving the datapath below.
    always_comb begin
        start_spike = 1'b0;
        end_spike   = 1'b0;
        rc_tick     = 1'b0;
        case (state)
            BELOW:   start_spike = v_valid && is_above;
            ABOVE:   end_spike   = v_valid && below_rearm;
            REFRAC:  rc_tick     = v_valid;
            default: ;
        endcase
    end

    // Timestamp, crossing time, refractory count, spike pulse/count and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts          <= '0;
            t0          <= '0;
            rc          <= '0;
            spike       <= 1'b0;
            spike_count <= '0;
            overflow    <= 1'b0;
        end else begin
            spike <= start_spike;
            if (start_spike && spike_count != 16'hFFFF) spike_count <= spike_count + 16'd1;
            if (v_valid)     ts <= ts + TS_W'(1);
            if (start_spike) t0 <= ts;
            if (end_spike)    rc <= refrac_cycles;
            else if (rc_tick) rc <= rc - REFRAC_W'(1);
            if (fifo_drop)   overflow <= 1'b1;
        end
    end

`ifdef HH_SPIKE_PEAK_EN
    logic signed [W-1:0] pk;

    // Running maximum while the voltage stays above the re-arm level.
    always_ff @(posedge clk) begin
        if (reset) begin
            pk <= '0;
        end else if (start_spike) begin
            pk <= $signed(v_mem);
        end else if (state == ABOVE && v_valid && !below_rearm && $signed(v_mem) > pk) begin
            pk <= $signed(v_mem);
        end
    end

    // Event record assembled from the crossing time and the tracked peak.
    always_comb begin
        evt_in      = '0;
        evt_in.ts   = t0;
        evt_in.peak = pk;
    end

    assign evt_peak = evt_head.peak;
`else
    logic unused_peak;

    // Event record carries only the crossing time in this build.
    always_comb begin
        evt_in    = '0;
        evt_in.ts = t0;
    end

    assign evt_peak    = '0;
    assign unused_peak = ^evt_head.peak;
`endif

    hh_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (end_spike),
        .push_data(evt_in),
        .pop      (evt_ready),
        .head     (evt_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    assign evt_valid = !fifo_empty;
    assign evt_time  = evt_head.ts;

endmodule

// File: tb/tb_hh_spike_detector.sv
// Self-checking bench for hh_spike_detector: directed scenarios plus random
// stimulus, all compared against a behavioural reference model.
// Honours HH_SPIKE_PEAK_EN the same way as the design.
module tb_hh_spike_detector;

    localparam int W     = 22;
    localparam int TS_W  = 16;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    v_mem;
    logic            v_valid;
    logic [W-1:0]    v_thresh;
    logic [W-1:0]    v_hyst;
    logic [7:0]      refrac_cycles;
    logic            spike;
    logic [15:0]     spike_count;
    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_time;
    logic [W-1:0]    evt_peak;
    logic            overflow;

    int vectors = 0;
    int errors  = 0;

    // Reference model state, expressed in terms of the behavioural rules.
    typedef struct {
        int t;
        int p;
    } evt_t;

    int   cfg_th, cfg_hy, cfg_rc;
    int   m_ts, m_ignore, m_t0, m_pk, m_count;
    bit   m_in_spike, m_spike, m_ovf;
    evt_t m_q[$];

    hh_spike_detector dut (
        .clk          (clk),
        .reset        (reset),
        .v_mem        (v_mem),
        .v_valid      (v_valid),
        .v_thresh     (v_thresh),
        .v_hyst       (v_hyst),
        .refrac_cycles(refrac_cycles),
        .spike        (spike),
        .spike_count  (spike_count),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_time     (evt_time),
        .evt_peak     (evt_peak),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("spike", 32'(spike), 32'(m_spike));
        checkOutput("spike_count", 32'(spike_count), m_count);
        checkOutput("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() > 0) begin
            checkOutput("evt_time", 32'(evt_time), m_q[0].t);
`ifdef HH_SPIKE_PEAK_EN
            checkOutput("evt_peak", 32'(evt_peak), m_q[0].p & 32'h3FFFFF);
`else
            checkOutput("evt_peak", 32'(evt_peak), 32'd0);
`endif
        end
    endtask

    task automatic modelReset();
        m_ts = 0; m_ignore = 0; m_t0 = 0; m_pk = 0; m_count = 0;
        m_in_spike = 0; m_spike = 0; m_ovf = 0;
        m_q.delete();
    endtask

    // One clock of the reference model, given the inputs present before the edge.
    task automatic modelStep(input int v, input bit valid, input bit ready);
        bit   pop_now  = (m_q.size() > 0) && ready;
        bit   push_now = 0;
        evt_t e;
        m_spike = 0;
        if (valid) begin
            if (m_ignore > 0) begin
                m_ignore--;
            end else if (!m_in_spike) begin
                if (v >= cfg_th) begin
                    m_in_spike = 1;
                    m_t0 = m_ts;
                    m_pk = v;
                    m_spike = 1;
                    if (m_count < 65535) m_count++;
                end
            end else if (v < cfg_th - cfg_hy) begin
                push_now   = 1;
                m_in_spike = 0;
                m_ignore   = cfg_rc;
            end else if (v > m_pk) begin
                m_pk = v;
            end
            m_ts = (m_ts + 1) & 32'hFFFF;
        end
        if (pop_now) void'(m_q.pop_front());
        if (push_now) begin
            if (m_q.size() < DEPTH) begin
                e.t = m_t0;
                e.p = m_pk;
                m_q.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic setCfg(input int th, input int hy, input int rc);
        cfg_th = th; cfg_hy = hy; cfg_rc = rc;
        v_thresh      = th[W-1:0];
        v_hyst        = hy[W-1:0];
        refrac_cycles = rc[7:0];
    endtask

    task automatic applyStimulus(input int v, input bit valid, input bit ready);
        v_mem     = v[W-1:0];
        v_valid   = valid;
        evt_ready = ready;
        modelStep(v, valid, ready);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic doReset(input int n);
        reset   = 1'b1;
        v_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        modelReset();
        checkAll();
        reset = 1'b0;
    endtask

    task automatic feed(input int vals[$], input bit ready);
        foreach (vals[i]) applyStimulus(vals[i], 1'b1, ready);
    endtask

    initial begin
        int v;
        reset = 1'b1; v_mem = '0; v_valid = 1'b0; evt_ready = 1'b0;
        setCfg(100, 20, 3);
        modelReset();
        doReset(2);

        // Single spike, event held for inspection.
        feed('{-50, 50, 120, 180, 150, 70, -40}, 1'b0);
        checkOutput("single_count", 32'(spike_count), 32'd1);
        checkOutput("single_time", 32'(evt_time), 32'd2);
`ifdef HH_SPIKE_PEAK_EN
        checkOutput("single_peak", 32'(evt_peak), 32'd180);
`else
        checkOutput("single_peak", 32'(evt_peak), 32'd0);
`endif
        feed('{0, 0}, 1'b1);

        // Hysteresis: 90 must not re-arm.
        feed('{120, 90, 110, 60, 0, 0, 0, 0}, 1'b1);
        checkOutput("hyst_count", 32'(spike_count), 32'd2);

        // Refractory window: three ignored samples, fourth spikes.
        feed('{120, 0, 150, 150, 150}, 1'b1);
        checkOutput("refrac_hold", 32'(spike_count), 32'd3);
        feed('{150}, 1'b1);
        checkOutput("refrac_spike", 32'(spike_count), 32'd4);
        feed('{0}, 1'b1);
        setCfg(100, 20, 0);
        feed('{150, 0, 0, 0}, 1'b1);
        setCfg(100, 20, 0);
        feed('{150}, 1'b1);
        checkOutput("refrac0_spike", 32'(spike), 32'd1);
        feed('{0}, 1'b1);

        // Backpressure: five spikes into a four-deep FIFO.
        for (int k = 0; k < 5; k++) feed('{120, 0}, 1'b0);
        checkOutput("bp_overflow", 32'(overflow), 32'd1);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b0, 1'b1);
        checkOutput("bp_drained", 32'(evt_valid), 32'd0);
        checkOutput("bp_sticky", 32'(overflow), 32'd1);

        // Reset mid-spike discards the spike; ts restarts at 0.
        setCfg(100, 20, 3);
        feed('{120, 130}, 1'b0);
        doReset(2);
        checkOutput("rst_count", 32'(spike_count), 32'd0);
        feed('{70, 50, 120, 60}, 1'b0);
        checkOutput("rst_time", 32'(evt_time), 32'd2);
        feed('{0}, 1'b1);

        // Extreme re-arm level must not wrap into a positive value.
        setCfg(-2000000, 4000000, 3);
        feed('{-1900000, -2097152, -2097152, 0}, 1'b1);
        checkOutput("nowrap_valid", 32'(evt_valid), 32'd0);
        doReset(1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            if (n % 60 == 0) setCfg(100, int'($urandom_range(0, 60)), int'($urandom_range(0, 5)));
            if ($urandom_range(0, 19) == 0) v = ($urandom_range(0, 1) == 1) ? 2097151 : -2097152;
            else v = int'($urandom_range(0, 400)) - 100;
            applyStimulus(v, $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
